// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, next-PC source select used by the
// datapath, reset/NOP constants and a word-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,   // request outstanding on pc_q
    S_HOLD,  // response captured while the pipe is stalled
    S_DROP   // request still outstanding after a redirect
  } fetch_state_e;

  // Next-PC source selected by the ID-stage next-PC logic.
  typedef enum logic [1:0] {
    PC4,
    BEQ,
    JUMP,
    JR
  } pc_src_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry buffer with a valid flag. Used for the instruction word caught
// during a stall (hold_q) and for a redirect target waiting on an old request (tgt_q).
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         valid
);

  // Capture on load, drop the valid flag on clear; load wins if both are set.
  // NOTE: the data register is reset along with valid so nothing X ever reaches
  // the IF/ID register; a single entry costs nothing to reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= din;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, drives the instruction-memory handshake,
// loads the IF/ID register, honours stalls and ID-stage redirects.
// Build option FETCH_DELAY_SLOT_EN: branch-delay-slot semantics (the instruction
// after a taken control transfer is delivered, no IF/ID flush). Undefined: the
// wrong-path fetch is squashed and flush_ifid pulses on every accepted redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output logic [31:0]       if_instr,
  output logic              flush_ifid
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] tgt_aligned;
  logic              accept;

  logic              hold_load, hold_clear, hold_valid;
  logic [31:0]       hold_q;
  logic              tgt_load, tgt_clear, tgt_valid;
  logic [ADDR_W-1:0] tgt_q;

  // A redirect raised during a stall is ignored; ID presents it again afterwards.
  assign accept      = redirect_valid & ~stall;
  assign tgt_aligned = word_align(redirect_pc);
  assign pc_plus4    = pc_q + 32'd4;  // wraps modulo 2^32
  assign imem_req    = ~rst & (state != S_HOLD);
  assign imem_addr   = pc_q;
`ifdef FETCH_DELAY_SLOT_EN
  assign flush_ifid  = 1'b0;
`else
  assign flush_ifid  = accept;
`endif

  // Buffer control: catch a response that arrives while stalled, park a redirect
  // target while the old request is still outstanding.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    tgt_load   = 1'b0;
    tgt_clear  = 1'b0;
    case (state)
      S_REQ: begin
        hold_load = imem_ready & stall;
        tgt_load  = accept & ~imem_ready;
      end
      S_HOLD: begin
        hold_clear = ~stall;
        tgt_clear  = ~stall;
      end
      S_DROP: begin
        tgt_load  = accept & ~imem_ready;
`ifdef FETCH_DELAY_SLOT_EN
        hold_load = imem_ready & stall;
        tgt_clear = imem_ready & ~stall;
`else
        tgt_clear = imem_ready;
`endif
      end
      default: ;
    endcase
  end

  fetch_skid #(.W(32)) u_hold (
    .clk(clk), .rst(rst), .load(hold_load), .clear(hold_clear),
    .din(imem_rdata), .q(hold_q), .valid(hold_valid)
  );

  fetch_skid #(.W(ADDR_W)) u_tgt (
    .clk(clk), .rst(rst), .load(tgt_load), .clear(tgt_clear),
    .din(tgt_aligned), .q(tgt_q), .valid(tgt_valid)
  );

  // Fetch FSM: PC sequencing and the registered IF/ID outputs.
  // NOTE: non-blocking assignments only, so every branch sees pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_pc4   <= RESET_PC + 32'd4;
      if_instr <= INSTR_NOP;
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (imem_ready) begin
              if_valid <= 1'b1;
              if_pc    <= pc_q;
              if_pc4   <= pc_plus4;
              if_instr <= imem_rdata;
              pc_q     <= tgt_aligned;
            end else begin
              if_valid <= 1'b0;
              state    <= S_DROP;
            end
`else
            if_valid <= 1'b0;
            if (imem_ready) pc_q  <= tgt_aligned;
            else            state <= S_DROP;
`endif
          end else if (imem_ready && stall) begin
            state <= S_HOLD;
          end else if (imem_ready) begin
            if_valid <= 1'b1;
            if_pc    <= pc_q;
            if_pc4   <= pc_plus4;
            if_instr <= imem_rdata;
            pc_q     <= pc_plus4;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
`ifdef FETCH_DELAY_SLOT_EN
          if (!stall) begin
            if_valid <= hold_valid;
            if_pc    <= pc_q;
            if_pc4   <= pc_plus4;
            if_instr <= hold_q;
            pc_q     <= accept ? tgt_aligned : (tgt_valid ? tgt_q : pc_plus4);
            state    <= S_REQ;
          end
`else
          if (accept) begin
            if_valid <= 1'b0;
            pc_q     <= tgt_aligned;
            state    <= S_REQ;
          end else if (!stall) begin
            if_valid <= hold_valid;
            if_pc    <= pc_q;
            if_pc4   <= pc_plus4;
            if_instr <= hold_q;
            pc_q     <= pc_plus4;
            state    <= S_REQ;
          end
`endif
        end
        S_DROP: begin
`ifdef FETCH_DELAY_SLOT_EN
          if (imem_ready && stall) begin
            state <= S_HOLD;
          end else if (imem_ready) begin
            if_valid <= 1'b1;
            if_pc    <= pc_q;
            if_pc4   <= pc_plus4;
            if_instr <= imem_rdata;
            if (accept)         pc_q <= tgt_aligned;
            else if (tgt_valid) pc_q <= tgt_q;
            state    <= S_REQ;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
`else
          if (imem_ready) begin
            if (accept)         pc_q <= tgt_aligned;
            else if (tgt_valid) pc_q <= tgt_q;
            state <= S_REQ;
          end
`endif
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- IF-stage sequencer that owns the program counter and drives the instruction-memory request handshake.
- Loads the IF/ID register (if_pc, if_pc4, if_instr, if_valid).
- Applies hazard-unit stalls and redirects from the ID-stage next-PC logic (branch, j/jal, jr).
- On a taken redirect, discards the wrong-path fetch and pulses the IF/ID flush.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
ADDR_W, 32, PC and address width; must be 32.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous active-high reset.
stall  input  1  hazard unit: hold IF/ID and PC.
redirect_valid  input  1  ID stage: control flow is taken this cycle.
redirect_pc  input  32  target from next-PC logic.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address (= pc_q).
imem_ready  input  1  response valid this cycle; completes the request.
imem_rdata  input  32  fetched instruction.
if_valid  output  1  IF/ID holds a real instruction.
if_pc  output  32  PC of if_instr.
if_pc4  output  32  if_pc + 4.
if_instr  output  32  instruction to ID.
flush_ifid  output  1  one-cycle kill of the IF/ID contents.

Behaviour:
- Reset (async, all state): pc_q=RESET_PC, state=S_REQ, if_valid=0, if_pc=RESET_PC, if_pc4=RESET_PC+4, if_instr=0, hold_q=0.
  - imem_req is 0 while rst is asserted. The first request goes out in the first cycle after deassertion.
  - Reset mid-request abandons the request; a late imem_ready is ignored.
- States: S_REQ (fetching pc_q), S_HOLD (response buffered while stalled), S_DROP (wrong-path request still outstanding).
- Handshake:
  - imem_req=1 in S_REQ and S_DROP.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - Transfer completes on the cycle imem_req and imem_ready are both 1. Zero-wait memory (ready the same cycle) gives one instruction per cycle.
- Redirect accepted = redirect_valid & ~stall. When stall=1, redirect is ignored; ID re-presents it after the stall.
- S_REQ:
  - ready, no stall, no redirect: if_* <= {pc_q, pc_q+4, rdata}, if_valid<=1, pc_q<=pc_q+4.
  - ready & stall: hold_q<=rdata, pc_q unchanged, go to S_HOLD. if_* is unchanged.
  - redirect accepted & ready: discard rdata, if_valid<=0, pc_q<=redirect_pc.
  - redirect accepted & ~ready: tgt_q<=redirect_pc, if_valid<=0, go to S_DROP.
- S_HOLD: imem_req=0.
  - When ~stall: present hold_q with pc_q into if_*, pc_q<=pc_q+4, go to S_REQ.
  - When a redirect is accepted instead: drop hold_q, if_valid<=0, pc_q<=redirect_pc, go to S_REQ.
- S_DROP: keep the request on the old address.
  - On ready: discard the data, pc_q<=tgt_q, go to S_REQ.
  - stall is ignored. if_valid stays 0.
- flush_ifid = accepted redirect, combinational, one cycle.
- pc_q+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- redirect_pc[1:0] is forced to 0.

Optional Feature:
FETCH_DELAY_SLOT_EN
- Defined (MIPS branch-delay-slot semantics):
  - An accepted redirect does not kill the in-flight or held instruction at branch+4. flush_ifid stays 0.
  - That instruction is delivered normally, then pc_q<=target. A pending-target register is used when the slot has not yet returned.
  - S_DROP becomes "finish slot, then jump".
- Undefined: squash behaviour as described above.

Decomposition:
- Package fetch_pkg: fetch_state_e enum (S_REQ, S_HOLD, S_DROP), RESET_PC_DEFAULT, INSTR_NOP=32'h0.
- Package shared with the datapath: pc_src enum (PC4, BEQ, JUMP, JR).
- Sub-module fetch_skid: the hold_q/tgt_q buffer with load/valid.

Test Plan:
- Reset release, zero-wait imem → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_pc lags by one cycle; if_valid=1 from the second cycle.
- stall=1 for 3 cycles with a response arriving in the first → S_HOLD, imem_req=0, if_* frozen; after release if_instr = buffered word, next address +4.
- Redirect to 0x3100 with ready=1 the same cycle → flush_ifid=1 for one cycle, if_valid=0 next cycle, next imem_addr=0x3100.
- Redirect to 0x3200 while imem_ready is delayed 2 cycles → imem_addr holds the old PC until ready, the data is never in if_*, then 0x3200 is fetched.
- redirect_valid & stall together → no flush, pc unchanged; redirect accepted once stall drops.
- With FETCH_DELAY_SLOT_EN, beq at 0x3000 taken to 0x3040 → 0x3004 delivered with if_valid=1, next fetch 0x3040, flush_ifid never asserts.
